// File: rtl/ram_result_scan.sv
// Walks the result RAM FIRST_ADDR..LAST_ADDR, streams each word and checks word[i] == word[i-1] + word[i-2].
// Three cycles per word (READ, CAPT, SEND); each out_ready_i=0 cycle in SEND holds the word and adds one cycle.
module ram_result_scan #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 63
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              ram_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [DATA_W-1:0] ram_dout_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_err_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   err_count_o,
    output logic [ADDR_W-1:0] first_err_addr_o
);
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_ADDR);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPT, S_SEND, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   prev1_q, prev1_d, prev2_q, prev2_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic                out_err_q, out_err_d;
    logic [ADDR_W:0]     err_count_q, err_count_d;
    logic [ADDR_W-1:0]   first_err_q, first_err_d;
    logic [DATA_W-1:0]   sum;

    // Compared against the words as read, so one bad word shows up as up to three mismatches.
    assign sum = prev1_q + prev2_q;

    always_comb begin
        state_d     = state_q;
        ram_addr_d  = ram_addr_q;
        idx_d       = idx_q;
        prev1_d     = prev1_q;
        prev2_d     = prev2_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        ram_en_o    = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                done_o = (state_q == S_DONE);
                if (start_i) begin
                    err_count_d = '0;
                    first_err_d = '0;
                    prev1_d     = '0;
                    prev2_d     = '0;
                    idx_d       = '0;
                    ram_addr_d  = FIRST;
                    state_d     = S_READ;
                end
            end
            S_READ: begin
                ram_en_o = 1'b1;
                busy_o   = 1'b1;
                state_d  = S_CAPT;
            end
            S_CAPT: begin
                busy_o     = 1'b1;
                out_data_d = ram_dout_i;
                out_addr_d = ram_addr_q;
                out_err_d  = (idx_q >= ADDR_W'(2)) && (ram_dout_i != sum);
                state_d    = S_SEND;
            end
            S_SEND: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    prev2_d = prev1_q;
                    prev1_d = out_data_q;
                    if (out_err_q) begin
                        err_count_d = err_count_q + (ADDR_W+1)'(1);
                        if (err_count_q == '0) first_err_d = out_addr_q;
                    end
                    // Stop on the address compare so LAST at the top of the range never wraps.
                    if (ram_addr_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        ram_addr_d = ram_addr_q + ADDR_W'(1);
                        idx_d      = idx_q + ADDR_W'(1);
                        state_d    = S_READ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ram_addr_q  <= FIRST;
            idx_q       <= '0;
            prev1_q     <= '0;
            prev2_q     <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            idx_q       <= idx_d;
            prev1_q     <= prev1_d;
            prev2_q     <= prev2_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
        end
    end

    assign ram_addr_o       = ram_addr_q;
    assign out_data_o       = out_data_q;
    assign out_addr_o       = out_addr_q;
    assign out_err_o        = out_err_q;
    assign err_count_o      = err_count_q;
    assign first_err_addr_o = first_err_q;
endmodule
